// File: rtl/imem_loader.sv
// Boot-stream loader: parses a length-prefixed byte stream, writes 32-bit words
// into instruction memory, verifies an XOR checksum and then releases the CPU.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        in_rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        out_ready,
  output logic        out_imem_wrt,
  output logic [31:0] out_imem_addr,
  output logic [31:0] out_imem_data,
  output logic        out_cpu_run,
  output logic        out_busy,
  output logic        out_error
);

  typedef enum logic [2:0] {
    S_LENHI,
    S_LENLO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] word_cnt_inc;

  // Outputs decode from state/registers only, so in_valid never reaches out_ready.
  always_comb begin
    out_ready     = (state_q == S_LENHI) || (state_q == S_LENLO) ||
                    (state_q == S_DATA)  || (state_q == S_CSUM);
    out_busy      = (state_q == S_LENLO) || (state_q == S_DATA) ||
                    (state_q == S_WRITE) || (state_q == S_CSUM);
    out_imem_wrt  = (state_q == S_WRITE);
    out_cpu_run   = (state_q == S_RUN);
    out_error     = (state_q == S_ERR);
    out_imem_addr = {16'd0, word_cnt_q};
    out_imem_data = asm_q;
  end

  always_comb begin
    xfer         = in_valid && out_ready;
    len_full     = {len_q[15:8], in_byte};
    word_cnt_inc = word_cnt_q + 16'd1;

    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;

    unique case (state_q)
      S_LENHI: begin
        if (xfer) begin
          len_d   = {in_byte, 8'd0};
          state_d = S_LENLO;
        end
      end
      S_LENLO: begin
        if (xfer) begin
          len_d = len_full;
          if ({16'd0, len_full} > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d      = {asm_q[23:0], in_byte};
          csum_d     = csum_q ^ in_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_inc;
        state_d    = (word_cnt_inc == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (in_byte == csum_q) ? S_RUN : S_ERR;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!in_rst_n) begin
      state_q    <= S_LENHI;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level reference model checked every
// cycle, plus literal expectations for each boot scenario.
module tb_imem_loader;

  localparam int MAXW = 256;

  logic        clk;
  logic        in_rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        out_ready;
  logic        out_imem_wrt;
  logic [31:0] out_imem_addr;
  logic [31:0] out_imem_data;
  logic        out_cpu_run;
  logic        out_busy;
  logic        out_error;

  imem_loader #(.MAX_WORDS(MAXW)) dut (
    .clk           (clk),
    .in_rst_n      (in_rst_n),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .out_ready     (out_ready),
    .out_imem_wrt  (out_imem_wrt),
    .out_imem_addr (out_imem_addr),
    .out_imem_data (out_imem_data),
    .out_cpu_run   (out_cpu_run),
    .out_busy      (out_busy),
    .out_error     (out_error)
  );

  always #5 clk = ~clk;

  // Reference model: position in the boot stream, not a state machine.
  int          m_pos;
  int          m_n;
  logic [7:0]  m_xor;
  logic [31:0] m_word;
  logic [31:0] m_wr_word;
  int          m_wr_addr;
  logic        m_wr;
  logic        m_run;
  logic        m_err;

  always @(posedge clk) begin
    if (!in_rst_n) begin
      m_pos = 0; m_n = 0; m_xor = '0; m_word = '0; m_wr_word = '0;
      m_wr_addr = 0; m_wr = 1'b0; m_run = 1'b0; m_err = 1'b0;
    end else if (m_wr) begin
      m_wr = 1'b0;
    end else if (in_valid && !m_run && !m_err) begin
      if (m_pos == 0) begin
        m_n = int'(in_byte) * 256;
      end else if (m_pos == 1) begin
        m_n = m_n + int'(in_byte);
        if (m_n > MAXW) m_err = 1'b1;
      end else if (m_pos < 2 + 4 * m_n) begin
        m_word = (m_word << 8) | {24'd0, in_byte};
        m_xor  = m_xor ^ in_byte;
        if ((m_pos - 2) % 4 == 3) begin
          m_wr      = 1'b1;
          m_wr_word = m_word;
          m_wr_addr = (m_pos - 2) / 4;
        end
      end else if (in_byte == m_xor) begin
        m_run = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_pos = m_pos + 1;
    end
  end

  int          n_chk;
  int          n_fail;
  int          cyc;
  bit          armed;
  int          wr_cyc[$];
  logic [31:0] wr_addr_l[$];
  logic [31:0] wr_data_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic idle;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        idle = m_wr || m_run || m_err;
        chk("ready", 32'(out_ready), 32'(!idle));
        chk("wrt", 32'(out_imem_wrt), 32'(m_wr));
        if (m_wr) begin
          chk("addr", out_imem_addr, 32'(m_wr_addr));
          chk("data", out_imem_data, m_wr_word);
        end
        chk("cpu_run", 32'(out_cpu_run), 32'(m_run));
        chk("error", 32'(out_error), 32'(m_err));
        chk("busy", 32'(out_busy), 32'(((m_pos > 0) || m_wr) && !m_run && !m_err));
        if (out_imem_wrt) begin
          wr_cyc.push_back(cyc);
          wr_addr_l.push_back(out_imem_addr);
          wr_data_l.push_back(out_imem_data);
        end
      end
    end
  endtask

  int stalls;

  // Holds the byte (with in_valid high) until a cycle where out_ready was 1.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 10; i++) begin
      rdy = out_ready;
      @(posedge clk);
      #2;
      if (rdy) return;
      stalls++;
    end
    chk("send_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    in_rst_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [7:0] s[$];
    clk = 1'b0; in_rst_n = 1'b0; in_valid = 1'b0; in_byte = '0;
    n_chk = 0; n_fail = 0; cyc = 0; armed = 0; stalls = 0;
    fork
      compare_loop();
    join_none

    // Reset values
    do_reset();
    armed = 1;
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_wrt", 32'(out_imem_wrt), 32'd0);
    chk("rst_addr", out_imem_addr, 32'd0);
    chk("rst_data", out_imem_data, 32'd0);
    chk("rst_run", 32'(out_cpu_run), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_error", 32'(out_error), 32'd0);

    // Two words, continuous in_valid
    base = wr_cyc.size(); stalls = 0;
    s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h44};
    send_stream(s);
    chk("a_nwr", 32'(wr_cyc.size() - base), 32'd2);
    if (wr_cyc.size() - base >= 2) begin
      chk("a_addr0", wr_addr_l[base], 32'd0);
      chk("a_data0", wr_data_l[base], 32'h11223344);
      chk("a_addr1", wr_addr_l[base+1], 32'd1);
      chk("a_data1", wr_data_l[base+1], 32'hA0B0C0D0);
      chk("a_spacing", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd5);
    end
    chk("a_stalls", 32'(stalls), 32'd2);
    chk("a_run", 32'(out_cpu_run), 32'd1);
    chk("a_error", 32'(out_error), 32'd0);
    chk("a_ready", 32'(out_ready), 32'd0);

    // Bad checksum
    do_reset();
    base = wr_cyc.size();
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_stream(s);
    chk("b_nwr", 32'(wr_cyc.size() - base), 32'd1);
    if (wr_cyc.size() > base) begin
      chk("b_addr0", wr_addr_l[base], 32'd0);
      chk("b_data0", wr_data_l[base], 32'hDEADBEEF);
    end
    chk("b_error", 32'(out_error), 32'd1);
    chk("b_run", 32'(out_cpu_run), 32'd0);

    // Empty image
    do_reset();
    base = wr_cyc.size();
    s = '{8'h00, 8'h00};
    send_stream(s);
    chk("c_run_early", 32'(out_cpu_run), 32'd0);
    chk("c_busy", 32'(out_busy), 32'd1);
    s = '{8'h00};
    send_stream(s);
    chk("c_run", 32'(out_cpu_run), 32'd1);
    chk("c_nwr", 32'(wr_cyc.size() - base), 32'd0);

    // Oversized length N=257
    do_reset();
    base = wr_cyc.size();
    s = '{8'h01, 8'h01};
    send_stream(s);
    chk("d_error", 32'(out_error), 32'd1);
    chk("d_ready", 32'(out_ready), 32'd0);
    in_valid = 1'b1; in_byte = 8'h55;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    chk("d_ready_hold", 32'(out_ready), 32'd0);
    chk("d_error_hold", 32'(out_error), 32'd1);
    chk("d_nwr", 32'(wr_cyc.size() - base), 32'd0);

    // Reset landing on the write cycle
    do_reset();
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(s);
    chk("w_wrt", 32'(out_imem_wrt), 32'd1);
    in_rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("w_wrt_abort", 32'(out_imem_wrt), 32'd0);
    chk("w_ready", 32'(out_ready), 32'd1);
    in_rst_n = 1'b1;

    // Reset after two data bytes, then a fresh image
    do_reset();
    s = '{8'h00, 8'h01, 8'h11, 8'h22};
    send_stream(s);
    do_reset();
    base = wr_cyc.size();
    s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_stream(s);
    chk("e_nwr", 32'(wr_cyc.size() - base), 32'd1);
    if (wr_cyc.size() > base) begin
      chk("e_addr0", wr_addr_l[base], 32'd0);
      chk("e_data0", wr_data_l[base], 32'h01020304);
    end
    chk("e_run", 32'(out_cpu_run), 32'd1);
    chk("e_error", 32'(out_error), 32'd0);

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
